// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store controller: request sizes, FSM states
// and small helpers for byte count and request legality.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_LAST = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_HALF: byte_count = 3'd2;
      SZ_WORD: byte_count = 3'd4;
      default: byte_count = 3'd1;
    endcase
  endfunction

  // Reserved size, or an access that is not naturally aligned.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_bad_req = 1'b0;
      SZ_HALF: is_bad_req = addr_lo[0];
      SZ_WORD: is_bad_req = (addr_lo != 2'b00);
      default: is_bad_req = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational size/sign extender from assembled little-endian load data.
// Zero latency, no flow control.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] raw_dat,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ext_dat
);

  always_comb begin
    ext_dat = raw_dat;
    case (size)
      SZ_BYTE: ext_dat = {{24{sgn & raw_dat[7]}}, raw_dat[7:0]};
      SZ_HALF: ext_dat = {{16{sgn & raw_dat[15]}}, raw_dat[15:0]};
      default: ext_dat = raw_dat;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller serialising CPU requests into byte-wide memory accesses.
// Latency: store N+1, load N+2, error 1 cycle; response held until resp_ready, one request in flight.
module mem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  import mem_access_pkg::*;

  localparam int RD_LAT = 1;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic              we_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       cap_q;
  logic              err_q;

  logic              accept;
  logic              req_bad;
  logic              resp_done;
  logic              cap_en;
  logic [1:0]        cap_lane;
  logic [31:0]       ext_dat;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  assign accept    = (state == ST_IDLE) && req_valid;
  assign req_bad   = is_bad_req(req_size, req_addr[1:0]);
  assign resp_done = (state == ST_RESP) && resp_ready;
  assign resp_err  = err_q;

  // Read data trails the strobe by RD_LAT, so lane k lands while byte k+1 is on the bus.
  assign cap_en   = !we_q && (((state == ST_XFER) && (cnt >= 3'(RD_LAT))) || (state == ST_LAST));
  assign cap_lane = (state == ST_LAST) ? 2'(nbytes - 3'd1) : 2'(cnt - 3'(RD_LAT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = req_bad ? ST_RESP : ST_XFER;
        end
      end
      ST_XFER: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = addr_q + ADDR_W'(cnt);
        if (we_q) begin
          mem_wdata = wdata_q[{cnt[1:0], 3'b000} +: 8];
        end
        if (cnt == nbytes - 3'd1) begin
          state_nxt = we_q ? ST_RESP : ST_LAST;
        end
      end
      ST_LAST: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (!we_q && !err_q) begin
          resp_rdata = ext_dat;
        end
        if (resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      nbytes  <= '0;
      cnt     <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      sgn_q   <= req_signed;
      size_q  <= req_size;
      addr_q  <= req_addr[ADDR_W-1:0];
      wdata_q <= req_wdata;
      nbytes  <= byte_count(req_size);
      cnt     <= '0;
      cap_q   <= '0;
      err_q   <= req_bad;
    end else begin
      if (state == ST_XFER) begin
        cnt <= cnt + 3'd1;
      end
      if (cap_en) begin
        cap_q[{cap_lane, 3'b000} +: 8] <= mem_rdata;
      end
      if (resp_done) begin
        err_q <= 1'b0;
      end
    end
  end

  load_extend u_load_extend (
    .raw_dat (cap_q),
    .size    (size_q),
    .sgn     (sgn_q),
    .ext_dat (ext_dat)
  );

  a_mem_only_in_xfer: assert property (@(posedge clk) disable iff (!rst)
    (mem_en || mem_we) |-> (state == ST_XFER));
  a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst)
    req_ready |-> !resp_valid);
  a_err_no_mem: assert property (@(posedge clk) disable iff (!rst)
    err_q |-> !mem_en);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-wide memory model behind it.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem_model [0:1023] = '{default: 8'h00};

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_ctrl #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // Drives one request, checks every memory strobe and the response, then completes the handshake.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                         input int exp_nmem, input logic [31:0] exp_rdata, input logic exp_err);
    int cyc;
    int nmem;
    logic [31:0] sh;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    drive_req(we, size, sgn, addr, wdata);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc  = 1;
    nmem = 0;
    while (!resp_valid && cyc < 20) begin
      if (mem_en) begin
        sh = wdata >> (8 * nmem);
        check({tag, "_maddr"}, 32'(mem_addr), 32'((addr + 32'(nmem)) & 32'h3FF));
        check({tag, "_mwe"}, 32'(mem_we), 32'(we));
        check({tag, "_mwdata"}, 32'(mem_wdata), we ? 32'(sh[7:0]) : 32'd0);
        nmem++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_nmem"}, 32'(nmem), 32'(exp_nmem));
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, "_busy"}, 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, "_done"}, {30'd0, resp_valid, resp_err}, 32'd0);
  endtask

  initial begin
    int cyc;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = SZ_BYTE;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_ctl", {28'd0, resp_valid, resp_err, mem_en, mem_we}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_mwdata", 32'(mem_wdata), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_req("st_w",   1'b1, SZ_WORD, 1'b0, 32'h10, 32'hA1B2C3D4, 5, 4, 32'h0, 1'b0);
    check("st_w_mem10", 32'(mem_model[10'h10]), 32'hD4);
    check("st_w_mem13", 32'(mem_model[10'h13]), 32'hA1);
    run_req("ld_w",   1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 6, 4, 32'hA1B2C3D4, 1'b0);
    run_req("ld_bs",  1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 3, 1, 32'hFFFFFFA1, 1'b0);
    run_req("ld_bu",  1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 3, 1, 32'h000000A1, 1'b0);
    run_req("st_h",   1'b1, SZ_HALF, 1'b0, 32'h20, 32'h00008001, 3, 2, 32'h0, 1'b0);
    run_req("ld_hs",  1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 4, 2, 32'hFFFF8001, 1'b0);
    run_req("ld_hu",  1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 4, 2, 32'h00008001, 1'b0);
    run_req("err_w",  1'b0, SZ_WORD, 1'b1, 32'h22, 32'h0, 1, 0, 32'h0, 1'b1);
    run_req("err_h",  1'b0, SZ_HALF, 1'b1, 32'h21, 32'h0, 1, 0, 32'h0, 1'b1);
    run_req("err_sz", 1'b1, SZ_RSVD, 1'b0, 32'h30, 32'hFFFFFFFF, 1, 0, 32'h0, 1'b1);
    run_req("st_b_hi", 1'b1, SZ_BYTE, 1'b0, 32'h450, 32'h0000005A, 2, 1, 32'h0, 1'b0);
    run_req("ld_b_hi", 1'b0, SZ_BYTE, 1'b1, 32'h50, 32'h0, 3, 1, 32'h0000005A, 1'b0);

    // Backpressure: response held while a new request waits.
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    drive_req(1'b1, SZ_BYTE, 1'b0, 32'h60, 32'h00000077);
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp_lat", 32'(cyc), 32'd6);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_vld", 32'(resp_valid), 32'd1);
      check("bp_hold_rdata", resp_rdata, 32'hA1B2C3D4);
      check("bp_hold_err", 32'(resp_err), 32'd0);
      check("bp_hold_rdy", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("bp_idle_vld", 32'(resp_valid), 32'd0);
    check("bp_idle_rdy", 32'(req_ready), 32'd1);
    check("bp_idle_men", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_acc_rdy", 32'(req_ready), 32'd0);
    check("bp_acc_men", {30'd0, mem_en, mem_we}, 32'd3);
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bp_st_lat", 32'(cyc), 32'd2);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("bp_st_mem", 32'(mem_model[10'h60]), 32'h77);

    // Reset in the second byte cycle of a word store.
    drive_req(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11223344);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rx_c1_we", 32'(mem_we), 32'd1);
    @(posedge clk);
    #1;
    check("rx_c2_we", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check("rx_we_drop", {30'd0, mem_en, mem_we}, 32'd0);
    check("rx_rdy", 32'(req_ready), 32'd1);
    check("rx_vld", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rx_mem40", 32'(mem_model[10'h40]), 32'h44);
    check("rx_mem42", 32'(mem_model[10'h42]), 32'h00);
    check("rx_mem43", 32'(mem_model[10'h43]), 32'h00);
    run_req("rx_ld", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 6, 4, 32'h00000044, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
